// File: rtl/dlsc_wb_ram.sv
// Wishbone slave RAM with classic or pipelined handshake, byte-lane writes and configurable read latency.
// Define DLSC_WB_RAM_ERR_EN to answer out-of-range addresses with wb_err_o instead of aliasing.
module dlsc_wb_ram #(
    parameter int unsigned WB_PIPELINE = 0,
    parameter int unsigned DATA        = 32,
    parameter int unsigned ADDR        = 32,
    parameter int unsigned MEM_ADDR    = 10,
    parameter int unsigned LATENCY     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [ADDR-1:0]     wb_adr_i,
    input  logic [2:0]          wb_cti_i,
    input  logic [DATA-1:0]     wb_dat_i,
    input  logic [DATA/8-1:0]   wb_sel_i,
    output logic                wb_stall_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic [DATA-1:0]     wb_dat_o
);

    localparam int unsigned STRB  = DATA / 8;
    localparam int unsigned LSB   = $clog2(STRB);
    localparam int unsigned DEPTH = 1 << MEM_ADDR;
    localparam int unsigned PD    = (LATENCY > 0) ? LATENCY : 1;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    logic [DATA-1:0]     mem [DEPTH];
    logic [MEM_ADDR-1:0] idx;
    logic [DATA-1:0]     rd_data;
    logic                oor;
    logic                acc;
    logic                unused_bits;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;

    logic [PD-1:0]       pv, pwe, perr;
    logic [DATA-1:0]     pdat [PD];
    logic                src_v, src_we, src_err;
    logic [DATA-1:0]     src_dat;

    assign idx         = wb_adr_i[MEM_ADDR+LSB-1:LSB];
    assign rd_data     = mem[idx];
    assign unused_bits = ^{wb_cti_i, wb_adr_i};
    assign wb_stall_o  = 1'b0;

`ifdef DLSC_WB_RAM_ERR_EN
    assign oor = |wb_adr_i[ADDR-1:MEM_ADDR+LSB];
`else
    assign oor = 1'b0;
`endif

    // Classic mode only takes a new strobe once the previous access has been answered.
    assign acc = wb_cyc_i & wb_stb_i & ((WB_PIPELINE != 0) || (state == ST_IDLE));

    // Byte-lane write commit; out-of-range writes are discarded.
    always_ff @(posedge clk) begin
        if (acc && wb_we_i && !oor) begin
            for (int b = 0; b < int'(STRB); b++) begin
                if (wb_sel_i[b]) mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    // Read data travels alongside the control pipe; no reset needed on the data path.
    always_ff @(posedge clk) begin
        pdat[0] <= rd_data;
        for (int i = 1; i < int'(PD); i++) pdat[i] <= pdat[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv   <= '0;
            pwe  <= '0;
            perr <= '0;
        end else begin
            pv[0]   <= acc;
            pwe[0]  <= wb_we_i;
            perr[0] <= oor;
            for (int i = 1; i < int'(PD); i++) begin
                pv[i]   <= pv[i-1];
                pwe[i]  <= pwe[i-1];
                perr[i] <= perr[i-1];
            end
            if (!wb_cyc_i) pv <= '0;
        end
    end

    assign src_v   = (LATENCY == 0) ? acc      : pv[PD-1];
    assign src_we  = (LATENCY == 0) ? wb_we_i  : pwe[PD-1];
    assign src_err = (LATENCY == 0) ? oor      : perr[PD-1];
    assign src_dat = (LATENCY == 0) ? rd_data  : pdat[PD-1];

    // Response register: dropping cyc kills whatever is about to emerge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_cyc_i & src_v & ~src_err;
            wb_err_o <= wb_cyc_i & src_v & src_err;
            if (wb_cyc_i && src_v && !src_we && !src_err) wb_dat_o <= src_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Classic handshake sequencing; WAIT length matches the response pipe depth.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!wb_cyc_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wb_stb_i) begin
                        if (LATENCY == 0) begin
                            state_nxt = ST_ACK;
                        end else begin
                            state_nxt = ST_WAIT;
                            cnt_nxt   = CNT_W'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) state_nxt = ST_ACK;
                    else           cnt_nxt   = cnt - 1'b1;
                end
                ST_ACK:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dlsc_wb_ram.sv
// Bench for dlsc_wb_ram: four instances (pipelined/classic, several latencies) share one stimulus
// stream and are each checked every cycle against a cycle-scheduled response model.
module tb_dlsc_wb_ram;

    localparam int ND = 4;
    localparam int MC = 4096;

`ifdef DLSC_WB_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [2:0]  cti;
    logic [3:0]  sel;

    logic        ack_w   [ND];
    logic        err_w   [ND];
    logic        stall_w [ND];
    logic [31:0] dat_w   [ND];

    always #5 clk = ~clk;

    dlsc_wb_ram #(.WB_PIPELINE(1), .LATENCY(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_cti_i(cti), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_stall_o(stall_w[0]),
        .wb_ack_o(ack_w[0]), .wb_err_o(err_w[0]), .wb_dat_o(dat_w[0]));
    dlsc_wb_ram #(.WB_PIPELINE(0), .LATENCY(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_cti_i(cti), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_stall_o(stall_w[1]),
        .wb_ack_o(ack_w[1]), .wb_err_o(err_w[1]), .wb_dat_o(dat_w[1]));
    dlsc_wb_ram #(.WB_PIPELINE(1), .LATENCY(4)) u_p4 (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_cti_i(cti), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_stall_o(stall_w[2]),
        .wb_ack_o(ack_w[2]), .wb_err_o(err_w[2]), .wb_dat_o(dat_w[2]));
    dlsc_wb_ram #(.WB_PIPELINE(0), .LATENCY(0)) u_c0 (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_cti_i(cti), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_stall_o(stall_w[3]),
        .wb_ack_o(ack_w[3]), .wb_err_o(err_w[3]), .wb_dat_o(dat_w[3]));

    // Model: expected response per DUT per cycle, plus a word-array image of each RAM.
    bit          e_ack [ND][MC];
    bit          e_err [ND][MC];
    bit          e_rd  [ND][MC];
    logic [31:0] e_dat [ND][MC];
    logic [31:0] mmem  [ND][1024];
    logic [31:0] last_rd   [ND];
    int          next_free [ND];
    int          ack_cnt   [ND];
    int          err_cnt   [ND];
    int          cyc_n;
    int          checks;
    int          failures;

    function automatic bit is_pipe(input int d);
        return (d == 0) || (d == 2);
    endfunction

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d cycle=%0d observed=%h expected=%h", tag, d, cyc_n, obs, exp);
        end
    endtask

    task automatic check_cycle();
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            if (e_ack[d][cyc_n] && e_rd[d][cyc_n]) last_rd[d] = e_dat[d][cyc_n];
            chk("ack",   d, 32'(ack_w[d]),   32'(e_ack[d][cyc_n]));
            chk("err",   d, 32'(err_w[d]),   32'(e_err[d][cyc_n]));
            chk("stall", d, 32'(stall_w[d]), 32'd0);
            chk("dat",   d, dat_w[d],        last_rd[d]);
            ack_cnt[d] += int'(ack_w[d]);
            err_cnt[d] += int'(err_w[d]);
        end
    endtask

    task automatic drive(input bit c, input bit s, input bit w, input logic [31:0] a,
                         input logic [31:0] dv, input logic [3:0] sl);
        int due;
        int idx;
        bit oor;
        cyc  = c;
        stb  = s;
        we   = w;
        adr  = a;
        wdat = dv;
        sel  = sl;
        cti  = 3'($urandom_range(0, 7));
        for (int d = 0; d < ND; d++) begin
            if (!c) begin
                for (int k = cyc_n + 1; k < cyc_n + 7; k++) begin
                    e_ack[d][k] = 1'b0;
                    e_err[d][k] = 1'b0;
                    e_rd[d][k]  = 1'b0;
                end
                next_free[d] = cyc_n + 1;
            end else if (s && (is_pipe(d) || cyc_n >= next_free[d])) begin
                due = cyc_n + lat_of(d) + 1;
                oor = ERR_EN && (a[31:12] != 20'd0);
                idx = int'(a[11:2]);
                if (!is_pipe(d)) next_free[d] = due + 1;
                if (oor) begin
                    e_err[d][due] = 1'b1;
                end else begin
                    e_ack[d][due] = 1'b1;
                    if (!w) begin
                        e_rd[d][due]  = 1'b1;
                        e_dat[d][due] = mmem[d][idx];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (sl[b]) mmem[d][idx][8*b +: 8] = dv[8*b +: 8];
                    end
                end
            end
        end
        cyc_n++;
    endtask

    task automatic step(input bit c, input bit s, input bit w, input logic [31:0] a,
                        input logic [31:0] dv, input logic [3:0] sl);
        check_cycle();
        drive(c, s, w, a, dv, sl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic hold(input int n, input bit w, input logic [31:0] a, input logic [31:0] dv,
                        input logic [3:0] sl);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, w, a, dv, sl);
    endtask

    task automatic rand_step();
        logic [31:0] a;
        a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
        step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             a, $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic clear_counts();
        for (int d = 0; d < ND; d++) begin
            ack_cnt[d] = 0;
            err_cnt[d] = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; wdat = '0; sel = '0; cti = '0;
        cyc_n = 0; checks = 0; failures = 0;
        for (int d = 0; d < ND; d++) begin
            last_rd[d] = '0;
            next_free[d] = 0;
        end
        clear_counts();

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("reset_ack",   d, 32'(ack_w[d]),   32'd0);
            chk("reset_err",   d, 32'(err_w[d]),   32'd0);
            chk("reset_stall", d, 32'(stall_w[d]), 32'd0);
            chk("reset_dat",   d, dat_w[d],        32'd0);
        end
        rst_n = 1'b1;

        // Preload words 0..15; each write held long enough for every classic instance
        for (int w = 0; w < 16; w++) hold(4, 1'b1, 32'(w * 4), $urandom, 4'hF);
        idle(6);

        // Back-to-back write then read of word 0
        step(1'b1, 1'b1, 1'b1, 32'h0, 32'h1122_3344, 4'hF);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(6);

        // Byte-lane merge
        hold(4, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
        hold(4, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101);
        hold(4, 1'b0, 32'h10, 32'h0, 4'h0);
        idle(6);
        for (int d = 0; d < ND; d++) chk("lane_merge", d, dat_w[d], 32'hFFBB_FFDD);

        // Strobe held for 12 cycles: one ack per access, none repeated
        clear_counts();
        hold(12, 1'b0, 32'h8, 32'h0, 4'h0);
        idle(8);
        chk("held_stb_acks", 0, 32'(ack_cnt[0]), 32'd12);
        chk("held_stb_acks", 1, 32'(ack_cnt[1]), 32'd3);
        chk("held_stb_acks", 2, 32'(ack_cnt[2]), 32'd12);
        chk("held_stb_acks", 3, 32'(ack_cnt[3]), 32'd6);

        // Pipelined burst of 8 reads
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
        idle(8);

        // Abort: cyc dropped while responses are outstanding
        clear_counts();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
        idle(4);
        chk("abort_acks", 0, 32'(ack_cnt[0]), 32'd2);
        chk("abort_acks", 1, 32'(ack_cnt[1]), 32'd1);
        chk("abort_acks", 2, 32'(ack_cnt[2]), 32'd0);
        chk("abort_acks", 3, 32'(ack_cnt[3]), 32'd2);
        hold(4, 1'b0, 32'h4, 32'h0, 4'h0);
        idle(8);

        // Out-of-range write aliasing onto word 0
        clear_counts();
        hold(4, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF);
        idle(6);
        for (int d = 0; d < ND; d++) chk("oor_err_seen", d, 32'(err_cnt[d] != 0), 32'(ERR_EN));
        hold(4, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(6);
        for (int d = 0; d < ND; d++)
            chk("oor_word0", d, dat_w[d], ERR_EN ? 32'h1122_3344 : 32'hDEAD_BEEF);

        // Random traffic
        for (int i = 0; i < 600; i++) rand_step();
        idle(8);

        // Asynchronous reset in the middle of a read burst
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        check_cycle();
        chk("pre_reset_ack", 0, 32'(ack_w[0]), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("async_rst_ack", d, 32'(ack_w[d]), 32'd0);
            chk("async_rst_err", d, 32'(err_w[d]), 32'd0);
            chk("async_rst_dat", d, dat_w[d],      32'd0);
            last_rd[d] = '0;
        end
        check_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b1;
        idle(4);
        for (int i = 0; i < 60; i++) rand_step();
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
